// File: rtl/keccak_nf_pkg.sv
// rtl/keccak_nf_pkg.sv - shared types and constants for the masked Keccak-f[200] round controller
package keccak_nf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CF   = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int LANE_W   = 8;
  localparam int N_SHARES = 3;
  localparam int NR_MAX   = 18;

  // Iota constants of Keccak-f[1600] truncated to the 8-bit lane
  localparam logic [LANE_W-1:0] KECCAK200_RC [0:NR_MAX-1] = '{
    8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
    8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80
  };

endpackage

// File: rtl/keccak_nf_rc_rom.sv
// rtl/keccak_nf_rc_rom.sv - round index to iota constant lookup, forced to zero when not enabled
module keccak_nf_rc_rom
  import keccak_nf_pkg::*;
(
  input  logic              i_en,
  input  logic [4:0]        i_round,
  output logic [LANE_W-1:0] o_rc
);

  always_comb begin
    o_rc = '0;
    if (i_en && (i_round < 5'(NR_MAX))) begin
      o_rc = KECCAK200_RC[i_round];
    end
  end

endmodule

// File: rtl/keccak_nf_round_ctrl.sv
// rtl/keccak_nf_round_ctrl.sv - load / chi-register / state-update sequencer for the NullFresh Keccak-f[200] core
module keccak_nf_round_ctrl
  import keccak_nf_pkg::*;
#(
  parameter int NR = 18,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  output logic         ready_o,
  output logic         load_en_o,
  output logic         cf_en_o,
  output logic         st_en_o,
  output logic [W-1:0] rc_o,
  output logic [4:0]   round_o,
  output logic         last_o,
  output logic         done_o
);

  if (W != LANE_W) begin : g_bad_w
    $error("keccak_nf_round_ctrl: W must be 8");
  end
  if ((NR < 1) || (NR > NR_MAX)) begin : g_bad_nr
    $error("keccak_nf_round_ctrl: NR must be 1..18");
  end

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_round;
  logic       w_last_round;

  assign w_last_round = (r_round == 5'(NR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_next;
      // Cleared on LOAD entry so round_o already reads 0 while LOAD is active
      if ((r_state == IDLE) && start_i) begin
        r_round <= '0;
      end else if ((r_state == UPD) && !w_last_round) begin
        r_round <= r_round + 5'd1;
      end
    end
  end

  // Enables decode only from r_state, so they are one-hot by construction
  always_comb begin
    w_next    = r_state;
    ready_o   = 1'b0;
    load_en_o = 1'b0;
    cf_en_o   = 1'b0;
    st_en_o   = 1'b0;
    done_o    = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_next = LOAD;
      end
      LOAD: begin
        load_en_o = 1'b1;
        w_next    = CF;
      end
      CF: begin
        cf_en_o = 1'b1;
        w_next  = UPD;
      end
      UPD: begin
        st_en_o = 1'b1;
        w_next  = w_last_round ? DONE : CF;
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign round_o = r_round;
  assign last_o  = st_en_o && w_last_round;

  keccak_nf_rc_rom u_rc_rom (
    .i_en    (st_en_o),
    .i_round (r_round),
    .o_rc    (rc_o)
  );

endmodule
